// File: rtl/mult_pipe.sv
// Pipelined RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU).
// One operand stage followed by MULT_STAGES-1 result stages.
module mult_pipe #(
   parameter int XLEN        = 32,
   parameter int MULT_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             opcode_valid_i,
   input  logic [31:0]      opcode_opcode_i,
   input  logic [XLEN-1:0]  opcode_ra_operand_i,
   input  logic [XLEN-1:0]  opcode_rb_operand_i,
   input  logic [TAG_W-1:0] opcode_rd_idx_i,
   input  logic             hold_i,
   input  logic             flush_i,
   output logic             writeback_valid_o,
   output logic [TAG_W-1:0] writeback_rd_idx_o,
   output logic [XLEN-1:0]  writeback_value_o,
   output logic             busy_o
);

   localparam int NR = MULT_STAGES - 1;
   localparam int PW = 2 * XLEN + 2;

   localparam logic [31:0] INST_MUL      = 32'h0200_0033;
   localparam logic [31:0] INST_MULH     = 32'h0200_1033;
   localparam logic [31:0] INST_MULHSU   = 32'h0200_2033;
   localparam logic [31:0] INST_MULHU    = 32'h0200_3033;
   localparam logic [31:0] INST_MUL_MASK = 32'hfe00_707f;

   generate
      if (MULT_STAGES < 2 || MULT_STAGES > 4) begin : g_bad_stages
         $error("mult_pipe: MULT_STAGES must be in 2..4");
      end
   endgenerate

   logic dec_mul;
   logic dec_mulh;
   logic dec_mulhsu;
   logic dec_mulhu;
   logic is_mul;
   logic accept;

   assign dec_mul    = (opcode_opcode_i & INST_MUL_MASK) == INST_MUL;
   assign dec_mulh   = (opcode_opcode_i & INST_MUL_MASK) == INST_MULH;
   assign dec_mulhsu = (opcode_opcode_i & INST_MUL_MASK) == INST_MULHSU;
   assign dec_mulhu  = (opcode_opcode_i & INST_MUL_MASK) == INST_MULHU;
   assign is_mul     = dec_mul | dec_mulh | dec_mulhsu | dec_mulhu;
   assign accept     = opcode_valid_i & is_mul & ~hold_i & ~flush_i;

   logic [XLEN:0]      a_d, a_q;
   logic [XLEN:0]      b_d, b_q;
   logic [TAG_W-1:0]   tag_d, tag_q;
   logic               hi_d, hi_q;
   logic               v1_d, v1_q;

   // Anything not accepted loads zeros, so E1 self-clears on idle cycles.
   always_comb begin
      a_d   = '0;
      b_d   = '0;
      tag_d = '0;
      hi_d  = 1'b0;
      v1_d  = 1'b0;
      if (accept) begin
         v1_d  = 1'b1;
         tag_d = opcode_rd_idx_i;
         hi_d  = ~dec_mul;
         a_d   = {(dec_mulh | dec_mulhsu) & opcode_ra_operand_i[XLEN-1],
                  opcode_ra_operand_i};
         b_d   = {dec_mulh & opcode_rb_operand_i[XLEN-1],
                  opcode_rb_operand_i};
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         a_q   <= '0;
         b_q   <= '0;
         tag_q <= '0;
         hi_q  <= 1'b0;
         v1_q  <= 1'b0;
      end else if (flush_i || !hold_i) begin
         a_q   <= a_d;
         b_q   <= b_d;
         tag_q <= tag_d;
         hi_q  <= hi_d;
         v1_q  <= v1_d;
      end
   end

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod;
   logic [XLEN-1:0]      res_d;
   logic                 unused_prod;

   assign a_ext = {{(XLEN+1){a_q[XLEN]}}, a_q};
   assign b_ext = {{(XLEN+1){b_q[XLEN]}}, b_q};
   assign prod  = a_ext * b_ext;
   assign res_d = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   assign unused_prod = ^prod[PW-1:2*XLEN];

   logic [NR-1:0]    sv_q;
   logic [TAG_W-1:0] stag_q [NR];
   logic [XLEN-1:0]  sres_q [NR];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sv_q <= '0;
         for (int i = 0; i < NR; i++) begin
            stag_q[i] <= '0;
            sres_q[i] <= '0;
         end
      end else if (flush_i) begin
         sv_q <= '0;
      end else if (!hold_i) begin
         sv_q[0]   <= v1_q;
         stag_q[0] <= tag_q;
         sres_q[0] <= res_d;
         for (int i = 1; i < NR; i++) begin
            sv_q[i]   <= sv_q[i-1];
            stag_q[i] <= stag_q[i-1];
            sres_q[i] <= sres_q[i-1];
         end
      end
   end

   assign writeback_valid_o  = sv_q[NR-1];
   assign writeback_rd_idx_o = stag_q[NR-1] & {TAG_W{sv_q[NR-1]}};
   assign writeback_value_o  = sres_q[NR-1] & {XLEN{sv_q[NR-1]}};
   assign busy_o             = v1_q | (|sv_q);

endmodule
